// File: rtl/pc_delay_requester_if.sv
// rtl/pc_delay_requester_if.sv - request/response signals between PC sequencer, its controller and the delay counter
interface pc_delay_requester_if #(
    parameter int PC_WIDTH = 8
);
    logic                stallReq;
    logic                pcLoad;
    logic [PC_WIDTH-1:0] pcLoadVal;
    logic                pcEn;
    logic                delayEn;
    logic [PC_WIDTH-1:0] pc;
    logic                busy;
    logic                timeout;

    modport master (
        output stallReq, pcLoad, pcLoadVal, pcEn,
        input  delayEn, pc, busy, timeout
    );

    modport slave (
        input  stallReq, pcLoad, pcLoadVal, pcEn,
        output delayEn, pc, busy, timeout
    );
endinterface

// File: rtl/pc_delay_requester.sv
// rtl/pc_delay_requester.sv - program counter that can pause for an external delay-counter handshake
module pc_delay_requester #(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  ACK_TIMEOUT  = 15,
    parameter int                  DONE_TIMEOUT = 1023
) (
    input logic                 clk,
    input logic                 rst_n,
    pc_delay_requester_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_COOL
    } state_t;

    localparam logic [9:0] ACK_LIMIT  = 10'(ACK_TIMEOUT);
    localparam logic [9:0] DONE_LIMIT = 10'(DONE_TIMEOUT);
    localparam logic [9:0] TIMER_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic [9:0]          timer;
    logic [9:0]          timer_nxt;
    logic [9:0]          timer_inc;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                timeout_q;
    logic                timeout_nxt;
    logic                delay_en_q;
    logic                pc_en_meta;
    logic                pc_en_s;

    // pcEn comes from another clock domain; synchronizer idles high (counter not running)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_en_meta <= 1'b1;
            pc_en_s    <= 1'b1;
        end else begin
            pc_en_meta <= bus.pcEn;
            pc_en_s    <= pc_en_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            pc_q       <= RESET_PC;
            timeout_q  <= 1'b0;
            delay_en_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pc_q       <= pc_nxt;
            timeout_q  <= timeout_nxt;
            delay_en_q <= (state_nxt == S_REQ) || (state_nxt == S_WAIT);
        end
    end

    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 10'd1;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pc_nxt      = pc_q;
        timeout_nxt = timeout_q;
        unique case (state)
            S_IDLE: begin
                if (bus.pcLoad) begin
                    pc_nxt = bus.pcLoadVal;
                end else if (bus.stallReq) begin
                    timer_nxt = '0;
                    state_nxt = S_REQ;
                end else begin
                    pc_nxt = pc_q + PC_WIDTH'(1);
                end
            end
            S_REQ: begin
                if (!pc_en_s) begin
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end else if (timer >= ACK_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_WAIT: begin
                if (pc_en_s) begin
                    state_nxt = S_DONE;
                end else if (timer >= DONE_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            // single advance per stall, then one quiet cycle so delayEn stays low >= 2 cycles
            S_DONE: begin
                pc_nxt    = pc_q + PC_WIDTH'(1);
                state_nxt = S_COOL;
            end
            S_COOL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.delayEn = delay_en_q;
    assign bus.pc      = pc_q;
    assign bus.busy    = (state != S_IDLE);
    assign bus.timeout = timeout_q;
endmodule

// File: doc/pc_delay_requester.md
PC_DELAY_REQUESTER -- requirements
Module: pc_delay_requester

Interface
REQ-001 Parameter PC_WIDTH, default 8, shall set the program-counter width.
REQ-002 Parameter RESET_PC, default 0, shall set the PC value loaded at reset.
REQ-003 Parameter ACK_TIMEOUT, default 15, shall set the maximum cycles in REQ waiting for pcEn to fall.
REQ-004 Parameter DONE_TIMEOUT, default 1023, shall set the maximum cycles in WAIT waiting for pcEn to rise; the timer is 10 bits.
REQ-005 clk  input  1  the single clock; all state changes occur on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 stallReq  input  1  request a delay before the next PC advance; level, sampled in IDLE only.
REQ-008 pcLoad  input  1  load pcLoadVal into PC; honoured in IDLE only.
REQ-009 pcLoadVal  input  PC_WIDTH  jump target.
REQ-010 pcEn  input  1  delay-counter response; low while the delay is running, high when complete; asynchronous to clk.
REQ-011 delayEn  output  1  delay request to the delay counter; the counter acts on its rising edge.
REQ-012 pc  output  PC_WIDTH  current program counter.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout  output  1  sticky flag, set on any handshake timeout.

Function
REQ-015 pcEn shall pass through a 2-flop synchronizer (pcEn_s); all FSM decisions shall use pcEn_s only.
REQ-016 The FSM shall have the states IDLE, REQ, WAIT, DONE and COOL, all registered.
REQ-017 IDLE, priority order:
- pcLoad=1: pc <= pcLoadVal, stay in IDLE.
- else stallReq=1: pc holds, timer cleared, next state REQ.
- else: pc <= pc+1, modulo 2^PC_WIDTH (all-ones wraps to 0).
REQ-018 delayEn shall be registered and high exactly in REQ and WAIT, so it rises the cycle after stallReq is sampled.
REQ-019 REQ: pcEn_s=0 -> WAIT with timer cleared; else timer reaches ACK_TIMEOUT -> DONE and set timeout; else timer increments.
REQ-020 WAIT: pcEn_s=1 -> DONE; else timer reaches DONE_TIMEOUT -> DONE and set timeout; else timer increments.
REQ-021 DONE: lasts one cycle; delayEn=0; pc <= pc+1 (one advance per stall); next state COOL.
REQ-022 COOL: lasts one cycle; delayEn=0; pc holds; next state IDLE. This guarantees delayEn stays low for at least 2 cycles between requests.
REQ-023 pcLoad and stallReq shall be ignored outside IDLE; a held stallReq shall start a new request on the cycle IDLE is re-entered.
REQ-024 pc shall never change in REQ, WAIT or COOL.
REQ-025 The timer shall saturate and never wrap.
REQ-026 timeout shall clear only on reset.

Reset
REQ-027 rst_n low shall immediately force: state IDLE, pc=RESET_PC, delayEn=0, busy=0, timeout=0, timer=0, synchronizer flops=1.
REQ-028 Reset asserted in mid-handshake shall drop delayEn asynchronously.
REQ-029 After reset release, the first rising edge shall behave as IDLE.

Verification
REQ-030 Free run: reset, stallReq=0 for 5 cycles -> pc = 0,1,2,3,4,5; busy=0; delayEn=0.
REQ-031 Normal stall from pc=3:
- stallReq=1 for 1 cycle -> delayEn rises 1 cycle later.
- Model drops pcEn 2 cycles later and raises it after 300 cycles -> DONE then pc=4, delayEn low for 2 or more cycles, timeout=0.
REQ-032 No response: pcEn held high with stallReq=1 -> delayEn high for ACK_TIMEOUT+1 cycles, then timeout=1, pc advances by exactly 1.
REQ-033 Priority and wrap:
- pc=8'hFF in IDLE -> pc=0 next cycle.
- pcLoad=1 with pcLoadVal=8'h40 and stallReq=1 together -> pc=8'h40, no request issued.
REQ-034 Mid-operation reset: rst_n low during WAIT -> delayEn=0 and pc=RESET_PC without a clock edge; timeout=0.
REQ-035 Back-to-back: stallReq held high for 3 requests -> 3 separate delayEn rising edges, each preceded by at least 2 low cycles; pc advances by exactly 3.
